mips_regfile_wb: RTL
====================

Name: mips_regfile_wb

Overview:
- Writeback end of the destination-register select path: consumes the 5-bit write-register index chosen by the RegDst mux, plus the 32-bit result chosen by the MemtoReg mux.
- Holds the 32 x 32-bit MIPS general-purpose register file.
- Provides two combinational read ports for decode and one debug read port.
- Sits between the writeback muxes and the ALU/branch operand inputs of the single-cycle datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W = 32.
- SP_INIT, 32'h7FFF_EFFC, reset value of $sp (r29).
- GP_INIT, 32'h1000_8000, reset value of $gp (r28).
- BYPASS, 1, 1 = same-cycle write is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- read_reg1  in  5  rs index.
- read_reg2  in  5  rt index.
- write_register  in  5  destination index, from the RegDst mux output.
- write_data  in  32  writeback value, from the MemtoReg mux output.
- RegWrite  in  1  write enable, from Control.
- read_data1  out  32  value of read_reg1.
- read_data2  out  32  value of read_reg2.
- dbg_addr  in  5  debug/testbench read index.
- dbg_data  out  32  value of dbg_addr; never bypassed.
- write_count  out  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high. The clock port is named clock and the reset port is named reset.
- Reset, sampled at a rising edge with reset=1:
  - r1..r31 <= 0, except r28 <= GP_INIT and r29 <= SP_INIT.
  - write_count <= 0.
  - Reset has priority over any write in the same cycle; a write presented during reset is dropped.
- Write:
  - Commits at a rising edge when reset=0, RegWrite=1 and write_register != 0.
  - regs[write_register] <= write_data and write_count increments, saturating at 16'hFFFF.
  - A write to r0 is dropped silently, and write_count does not increment.
- r0:
  - Has no storage; reads as 32'h0 on every port at all times, including during and after reset.
- Reads:
  - read_data1/2 and dbg_data are combinational from the indices. Latency is 0 cycles from the address; an updated value is visible the cycle after commit.
- Bypass (BYPASS=1):
  - If RegWrite=1, reset=0, write_register != 0 and write_register == read_regN, then read_dataN = write_data in the same cycle.
  - Both ports may bypass simultaneously.
  - Bypass never applies to index 0 or to dbg_data.
- Bypass off (BYPASS=0):
  - Read ports return the pre-edge stored value; the new value appears the next cycle.
- X-handling:
  - RegWrite=X or write_register=X outside reset is a bench error. The implementation adds a simulation-only assertion and no functional recovery.
- Widths:
  - No arithmetic except write_count. All indices are used unmodified; no truncation.
- No state machine; state is the 31 storage registers plus write_count.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W.
  - REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31.
  - Reset-value constants SP_INIT_DEF and GP_INIT_DEF.
  - The ctrl_t struct field for RegWrite (reused by Control).
- One sub-module is natural: regfile_read_port. It provides one index in and one data out, with r0 masking and optional bypass compare. It is instantiated twice for read_data1/2. dbg_data uses a plain indexed read.

Test Plan:
1. Reset, then read all 32 indices via dbg_addr -> r28=32'h1000_8000, r29=32'h7FFF_EFFC, all others 0; write_count=0.
2. RegWrite=1, write_register=8, write_data=32'hDEAD_BEEF, read_reg1=8 in the same cycle (BYPASS=1) -> read_data1=32'hDEAD_BEEF immediately; dbg_data at addr 8 shows the old value 0 until after the edge; write_count=1.
3. RegWrite=1, write_register=0, write_data=32'hFFFF_FFFF -> read_data1/2 with index 0 = 0 both before and after the edge; write_count unchanged.
4. reset=1 and RegWrite=1 with write_register=5, write_data=32'h1234 in the same cycle -> after the edge r5=0 and write_count=0.
5. Write r31=32'hA, then r31=32'hB on back-to-back cycles, read_reg1=read_reg2=31 -> cycle 1 both read 32'hA (bypass), cycle 2 both read 32'hB, cycle 3 both 32'hB; write_count=2.
6. BYPASS=0 build, write r9=32'h55 with read_reg2=9 -> read_data2=0 in the write cycle, 32'h55 the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and control types.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int WCNT_W = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int REG_GP = 28;
    localparam int REG_SP = 29;
    localparam int REG_RA = 31;

    localparam logic [DATA_W-1:0] SP_INIT_DEF = 32'h7FFF_EFFC;
    localparam logic [DATA_W-1:0] GP_INIT_DEF = 32'h1000_8000;

    // Control-word fields consumed by the writeback stage.
    typedef struct packed {
        logic reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_regfile_wb_if.sv
// Register-file bus: writeback inputs, decode read ports, debug port, write counter.
interface mips_regfile_wb_if;
    import mips_pkg::*;

    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic              RegWrite;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [WCNT_W-1:0] write_count;

    modport master (
        output read_reg1, read_reg2, write_register, write_data, RegWrite, dbg_addr,
        input  read_data1, read_data2, dbg_data, write_count
    );

    modport slave (
        input  read_reg1, read_reg2, write_register, write_data, RegWrite, dbg_addr,
        output read_data1, read_data2, dbg_data, write_count
    );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: r0 reads as zero, optional same-cycle write forwarding.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rf [0:(2**ADDR_W)-1],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    // Stored value with r0 masked, overridden by the in-flight write when forwarding.
    always_comb begin
        rd_data = (rd_idx == '0) ? '0 : rf[rd_idx];
        if (BYPASS && wr_en && (wr_idx != '0) && (wr_idx == rd_idx))
            rd_data = wr_data;
    end
endmodule

// File: rtl/mips_regfile_wb.sv
// 32 x 32 MIPS general-purpose register file at the writeback end of the datapath.
module mips_regfile_wb
    import mips_pkg::*;
#(
    parameter int                 DATA_W  = mips_pkg::DATA_W,
    parameter int                 ADDR_W  = mips_pkg::ADDR_W,
    parameter logic [DATA_W-1:0]  SP_INIT = SP_INIT_DEF,
    parameter logic [DATA_W-1:0]  GP_INIT = GP_INIT_DEF,
    parameter bit                 BYPASS  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    mips_regfile_wb_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;

    ctrl_t             ctrl;
    logic              wr_live;
    logic              commit;
    logic [DATA_W-1:0] regs    [1:DEPTH-1];
    logic [DATA_W-1:0] rf_view [0:DEPTH-1];
    logic [WCNT_W-1:0] wcnt;

    // Control word feeding this stage; a write is live only outside reset.
    always_comb begin
        ctrl.reg_write = bus.RegWrite;
        wr_live        = ctrl.reg_write && !reset;
        commit         = wr_live && (bus.write_register != REG_ZERO);
    end

    // Storage update: reset seeds $gp/$sp, writes to r0 never land, counter saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= '0;
            regs[REG_GP] <= GP_INIT;
            regs[REG_SP] <= SP_INIT;
            wcnt         <= '0;
        end else if (commit) begin
            regs[bus.write_register] <= bus.write_data;
            if (wcnt != '1)
                wcnt <= wcnt + 1'b1;
        end
    end

    // Full 32-entry view with a hard-wired zero in slot 0.
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < DEPTH; i++)
            rf_view[i] = regs[i];
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp1 (
        .rd_idx  (bus.read_reg1),
        .rf      (rf_view),
        .wr_en   (wr_live),
        .wr_idx  (bus.write_register),
        .wr_data (bus.write_data),
        .rd_data (bus.read_data1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp2 (
        .rd_idx  (bus.read_reg2),
        .rf      (rf_view),
        .wr_en   (wr_live),
        .wr_idx  (bus.write_register),
        .wr_data (bus.write_data),
        .rd_data (bus.read_data2)
    );

    assign bus.dbg_data    = rf_view[bus.dbg_addr];
    assign bus.write_count = wcnt;

    // Unknown write control outside reset means the upstream stage is broken.
    a_wr_known: assert property (@(posedge clock) disable iff (reset)
        !$isunknown({bus.RegWrite, bus.write_register}));
endmodule
